// File: rtl/cordic_div_pkg.sv
// Shared types and constants for the linear-vectoring CORDIC divider:
// front-end FSM states, the side-band record and the quotient scale.
package cordic_div_pkg;

  localparam int CDIV_DATA_WIDTH = 12;
  // z carries 2*DATA_WIDTH fractional bits; cordic_divider uses the same scale
  localparam int CDIV_Z_WIDTH    = 2 * CDIV_DATA_WIDTH;
  localparam int CDIV_SHIFT_W    = 5;
  localparam int CDIV_TAG_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_ISSUE
  } state_t;

  typedef struct packed {
    logic                      valid;
    logic [CDIV_SHIFT_W-1:0]   shift;
    logic                      zero;
    logic                      sat;
    logic [CDIV_TAG_WIDTH-1:0] tag;
  } sb_t;

endpackage

// File: rtl/cordic_sb_delay.sv
// Side-band delay line matching the latency of the CORDIC iteration stages.
// Only the valid bits are reset; payloads simply follow the data.
module cordic_sb_delay
  import cordic_div_pkg::*;
#(
  parameter int STAGES = 24
) (
  input  logic clk,
  input  logic rst,
  input  sb_t  sb_in,
  output sb_t  sb_out
);

  logic [STAGES-1:0] vld;
  sb_t               pay [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld <= (vld << 1) | STAGES'(sb_in.valid);
    end
  end

  always_ff @(posedge clk) begin
    pay[0] <= sb_in;
    for (int i = 1; i < STAGES; i++) begin
      pay[i] <= pay[i-1];
    end
  end

  always_comb begin
    sb_out       = pay[STAGES-1];
    sb_out.valid = vld[STAGES-1];
  end

endmodule

// File: rtl/cordic_div_prep.sv
// Operand front end for the CORDIC divider: accepts num/den, shifts the divisor
// left until it exceeds the numerator, then issues the stage-0 vector once.
module cordic_div_prep
  import cordic_div_pkg::*;
#(
  parameter int SUM_WIDTH  = 26,
  parameter int DATA_WIDTH = CDIV_DATA_WIDTH,
  parameter int STAGES     = 24,
  parameter int SHIFT_W    = CDIV_SHIFT_W,
  parameter int TAG_WIDTH  = CDIV_TAG_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SUM_WIDTH-1:0]    num_i,
  input  logic [SUM_WIDTH-1:0]    den_i,
  input  logic [TAG_WIDTH-1:0]    tag_i,
  output logic [SUM_WIDTH:0]      a_o,
  output logic [SUM_WIDTH-1:0]    b_o,
  output logic [2*DATA_WIDTH-1:0] z_o,
  output logic                    issue_valid_o,
  output logic                    sb_valid_o,
  output logic [SHIFT_W-1:0]      sb_shift_o,
  output logic                    sb_zero_o,
  output logic                    sb_sat_o,
  output logic [TAG_WIDTH-1:0]    sb_tag_o
);

  state_t                 state, state_next;
  logic [SUM_WIDTH-1:0]   num_r, den_r;
  logic [SHIFT_W-1:0]     k;
  logic [TAG_WIDTH-1:0]   tag_r;
  logic                   zero_r, sat_r;
  logic                   den_is_zero, den_above, den_top;
  sb_t                    sb_in, sb_out;

  // NORM priority: zero divisor, already normalised, then saturation, else shift
  assign den_is_zero = (den_r == '0);
  assign den_above   = (den_r > num_r);
  assign den_top     = den_r[SUM_WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      num_r  <= '0;
      den_r  <= '0;
      k      <= '0;
      tag_r  <= '0;
      zero_r <= 1'b0;
      sat_r  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            num_r  <= num_i;
            den_r  <= den_i;
            tag_r  <= tag_i;
            k      <= '0;
            zero_r <= 1'b0;
            sat_r  <= 1'b0;
          end
        end
        ST_NORM: begin
          if (den_is_zero) begin
            zero_r <= 1'b1;
          end else if (den_above) begin
            k <= k;
          end else if (den_top) begin
            sat_r <= 1'b1;
          end else begin
            den_r <= {den_r[SUM_WIDTH-2:0], 1'b0};
            k     <= k + SHIFT_W'(1);
          end
        end
        default: begin
          k <= k;
        end
      endcase
    end
  end

  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    issue_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_NORM;
      end
      ST_NORM: begin
        if (den_is_zero || den_above || den_top) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        issue_valid_o = 1'b1;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sb_in.valid = issue_valid_o;
    sb_in.shift = k;
    sb_in.zero  = zero_r;
    sb_in.sat   = sat_r;
    sb_in.tag   = tag_r;
  end

  cordic_sb_delay #(
    .STAGES (STAGES)
  ) u_sb_delay (
    .clk    (clk),
    .rst    (rst),
    .sb_in  (sb_in),
    .sb_out (sb_out)
  );

  assign a_o        = {1'b0, num_r};
  assign b_o        = den_r;
  assign z_o        = '0;
  assign sb_valid_o = sb_out.valid;
  assign sb_shift_o = sb_out.shift;
  assign sb_zero_o  = sb_out.zero;
  assign sb_sat_o   = sb_out.sat;
  assign sb_tag_o   = sb_out.tag;

endmodule

// File: tb/tb_cordic_div_prep.sv
// Scoreboard bench for cordic_div_prep: expected issue vectors and side-band
// records are queued at accept time and compared when the DUT emits them.
module tb_cordic_div_prep;

  localparam int SW     = 26;
  localparam int STAGES = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] num_i, den_i;
  logic [7:0]    tag_i;
  logic [SW:0]   a_o;
  logic [SW-1:0] b_o;
  logic [23:0]   z_o;
  logic          issue_valid_o, sb_valid_o, sb_zero_o, sb_sat_o;
  logic [4:0]    sb_shift_o;
  logic [7:0]    sb_tag_o;

  typedef struct {
    logic [SW:0]   a;
    logic [SW-1:0] b;
    int            cyc;
  } iss_t;

  typedef struct {
    logic [4:0] shift;
    logic       zero;
    logic       sat;
    logic [7:0] tag;
    int         cyc;
  } sbx_t;

  iss_t issQ[$];
  sbx_t sbQ[$];
  iss_t ie;
  sbx_t se;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nextFreeCyc = 0;

  cordic_div_prep dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .num_i         (num_i),
    .den_i         (den_i),
    .tag_i         (tag_i),
    .a_o           (a_o),
    .b_o           (b_o),
    .z_o           (z_o),
    .issue_valid_o (issue_valid_o),
    .sb_valid_o    (sb_valid_o),
    .sb_shift_o    (sb_shift_o),
    .sb_zero_o     (sb_zero_o),
    .sb_sat_o      (sb_sat_o),
    .sb_tag_o      (sb_tag_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Expected k/b/zero/sat come from hand-worked values in the stimulus list
  task automatic applyStimulus(input logic [SW-1:0] num, input logic [SW-1:0] den, input logic [7:0] tag,
                               input int expK, input logic [SW-1:0] expB, input logic expZero,
                               input logic expSat, input bit hold);
    int   waited;
    int   t;
    bit   accepted;
    iss_t ni;
    sbx_t ns;
    @(negedge clk);
    in_valid = 1'b1;
    num_i    = num;
    den_i    = den;
    tag_i    = tag;
    waited   = 0;
    accepted = 1'b0;
    forever begin
      checkOutput("in_ready", {63'd0, in_ready}, {63'd0, (cyc >= nextFreeCyc)});
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
      if (waited >= 64) begin
        checkOutput("accept_timeout", 64'd0, 64'd1);
        break;
      end
      @(negedge clk);
      waited++;
    end
    if (!accepted) begin
      in_valid = 1'b0;
      return;
    end
    t        = cyc;
    ni.a     = {1'b0, num};
    ni.b     = expB;
    ni.cyc   = t + 2 + expK;
    ns.shift = 5'(expK);
    ns.zero  = expZero;
    ns.sat   = expSat;
    ns.tag   = tag;
    ns.cyc   = t + 2 + expK + STAGES;
    issQ.push_back(ni);
    sbQ.push_back(ns);
    nextFreeCyc = t + 3 + expK;
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (issue_valid_o) begin
      if (issQ.size() == 0) begin
        checkOutput("unexpected_issue", 64'd1, 64'd0);
      end else begin
        ie = issQ.pop_front();
        checkOutput("issue_a", 64'(a_o), 64'(ie.a));
        checkOutput("issue_a_sign", {63'd0, a_o[SW]}, 64'd0);
        checkOutput("issue_b", 64'(b_o), 64'(ie.b));
        checkOutput("issue_z", 64'(z_o), 64'd0);
        checkOutput("issue_cycle", 64'(cyc), 64'(ie.cyc));
      end
    end
    if (sb_valid_o) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_sb", 64'd1, 64'd0);
      end else begin
        se = sbQ.pop_front();
        checkOutput("sb_shift", 64'(sb_shift_o), 64'(se.shift));
        checkOutput("sb_zero", {63'd0, sb_zero_o}, {63'd0, se.zero});
        checkOutput("sb_sat", {63'd0, sb_sat_o}, {63'd0, se.sat});
        checkOutput("sb_tag", 64'(sb_tag_o), 64'(se.tag));
        checkOutput("sb_cycle", 64'(cyc), 64'(se.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    num_i    = '0;
    den_i    = '0;
    tag_i    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_issue_valid", {63'd0, issue_valid_o}, 64'd0);
    checkOutput("rst_sb_valid", {63'd0, sb_valid_o}, 64'd0);
    checkOutput("rst_a", 64'(a_o), 64'd0);
    checkOutput("rst_b", 64'(b_o), 64'd0);
    checkOutput("rst_z", 64'(z_o), 64'd0);

    applyStimulus(26'd100, 26'd200, 8'd5, 0, 26'd200, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'd1000, 26'd3, 8'd6, 9, 26'd1536, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'd77, 26'd77, 8'd7, 1, 26'd154, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'd42, 26'd0, 8'd8, 0, 26'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(26'h3FFFFFF, 26'h2000000, 8'd9, 0, 26'h2000000, 1'b0, 1'b1, 1'b0);
    applyStimulus(26'd0, 26'd5, 8'd12, 0, 26'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'h1FFFFFF, 26'd1, 8'd13, 25, 26'h2000000, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'h2000000, 26'd1, 8'd14, 25, 26'h2000000, 1'b0, 1'b1, 1'b0);

    // in_valid stays high across two back-to-back requests
    applyStimulus(26'd100, 26'd200, 8'd10, 0, 26'd200, 1'b0, 1'b0, 1'b1);
    applyStimulus(26'd7, 26'd1, 8'd11, 3, 26'd8, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 200 && (issQ.size() != 0 || sbQ.size() != 0); i++) @(negedge clk);
    checkOutput("drain_issue", 64'(issQ.size()), 64'd0);
    checkOutput("drain_sb", 64'(sbQ.size()), 64'd0);

    // Reset while one side-band is still in the delay line and another request is normalising
    applyStimulus(26'd100, 26'd200, 8'd20, 0, 26'd200, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'd1000, 26'd3, 8'd21, 9, 26'd1536, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issQ.delete();
    sbQ.delete();
    @(negedge clk);
    rst = 1'b0;
    nextFreeCyc = 0;
    checkOutput("rst_mid_sb_valid", {63'd0, sb_valid_o}, 64'd0);
    checkOutput("rst_mid_issue", {63'd0, issue_valid_o}, 64'd0);
    @(negedge clk);
    checkOutput("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < STAGES + 4; i++) begin
      checkOutput("post_rst_sb_valid", {63'd0, sb_valid_o}, 64'd0);
      checkOutput("post_rst_issue", {63'd0, issue_valid_o}, 64'd0);
      @(negedge clk);
    end

    applyStimulus(26'd1000, 26'd3, 8'd22, 9, 26'd1536, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200 && (issQ.size() != 0 || sbQ.size() != 0); i++) @(negedge clk);
    checkOutput("final_drain_issue", 64'(issQ.size()), 64'd0);
    checkOutput("final_drain_sb", 64'(sbQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
